// File: rtl/pb_pkg.sv
// Shared types and constants for the push-button operand loader.
package pb_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int OPW       = 4;
    localparam int IDXW      = 3;

    typedef logic [OPW-1:0]       operand_t;
    typedef logic [IDXW-1:0]      idx_t;
    typedef logic [NUM_SLOTS-1:0] mask_t;

    // Loader control states.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam idx_t  LAST_IDX  = idx_t'(NUM_SLOTS - 1);
    localparam mask_t FULL_MASK = '1;

endpackage

// File: rtl/pb_operand_loader_if.sv
// Operand stream towards the downstream adder: valid/ready handshake plus
// the operand value and its slot number.
interface pb_operand_loader_if import pb_pkg::*; ();

    logic     out_valid;
    logic     out_ready;
    operand_t out_data;
    idx_t     out_idx;

    // Loader side drives the operand, consumer side drives ready.
    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/pb_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// single-cycle pulse when the debounced level rises.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic press
);

    // Counter wraps to the accept point after DEBOUNCE_CYCLES differing samples.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_q, press_d;

    // Count consecutive synchronized samples that disagree with the accepted level.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchronizer and debounce state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            sync1_q <= pb_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pb_operand_loader.sv
// Captures the Y operand into one of five slots on debounced button presses,
// then streams all five slots to the adder and pulses done.
module pb_operand_loader import pb_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PB1,
    input  logic                       PB2,
    input  logic                       PB3,
    input  logic                       PB4,
    input  logic                       PB5,
    input  operand_t                   Y,
    pb_operand_loader_if.master        out_if,
    output mask_t                      loaded_mask,
    output logic                       busy,
    output logic                       done
);

    mask_t    pb_raw;
    mask_t    press;

    state_e   state_q, state_d;
    operand_t slot_q [NUM_SLOTS];
    operand_t slot_d [NUM_SLOTS];
    mask_t    mask_q, mask_d;
    logic     out_valid_q, out_valid_d;
    operand_t out_data_q, out_data_d;
    idx_t     out_idx_q, out_idx_d;
    idx_t     next_idx;
    logic     busy_q, busy_d;
    logic     done_q, done_d;

    assign pb_raw = {PB5, PB4, PB3, PB2, PB1};

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_btn
        pb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .pb_raw (pb_raw[g]),
            .press  (press[g])
        );
    end

    // Next-state, slot capture and registered stream outputs.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        next_idx    = out_idx_q + idx_t'(1);

        unique case (state_q)
            COLLECT: begin
                // Simultaneous presses all take the same Y.
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (press[k]) begin
                        slot_d[k] = Y;
                        mask_d[k] = 1'b1;
                    end
                end
                // Mask became full on the previous edge: start streaming.
                if (mask_q == FULL_MASK) begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    out_idx_d   = '0;
                    out_data_d  = slot_d[0];
                end
            end

            SEND: begin
                // Presses are ignored here; the operand holds until ready.
                if (out_if.out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        state_d     = FLUSH;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        out_idx_d   = '0;
                        out_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        out_idx_d  = next_idx;
                        out_data_d = slot_q[next_idx];
                    end
                end
            end

            FLUSH: begin
                // Slots keep their contents; only the mask restarts.
                mask_d  = '0;
                state_d = COLLECT;
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the slot array is small and must read as zero after reset, so it is reset explicitly.
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_idx   = out_idx_q;
    assign loaded_mask      = mask_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/pb_operand_loader.md
PB_OPERAND_LOADER -- requirements
Module: pb_operand_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples required before a button level is accepted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PB1..PB5  input  1 each  raw push-button levels, asynchronous to clk, active-high.
REQ-005 Y  input  4  operand value captured on an accepted press.
REQ-006 out_ready  input  1  downstream adder accepts the current operand.
REQ-007 out_valid  output  1  out_data/out_idx hold a valid operand.
REQ-008 out_data  output  4  operand value being streamed.
REQ-009 out_idx  output  3  slot number of out_data, 0..4 (slot 0 = PB1).
REQ-010 loaded_mask  output  5  bit k set when slot k holds a captured operand.
REQ-011 busy  output  1  high while in SEND.
REQ-012 done  output  1  one-cycle pulse after the last operand is accepted.

Function
REQ-013 Each PBk shall pass a 2-flop synchronizer and then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-014 A press is accepted on the cycle the debounced level rises 0->1; releases and held levels produce no further events.
REQ-015 FSM states: COLLECT, SEND, FLUSH; reset state COLLECT.
REQ-016 COLLECT: accepted press on PBk captures Y into slot k-1 and sets loaded_mask[k-1]; a repeat press overwrites that slot.
REQ-017 Simultaneous accepted presses in one cycle shall all capture the same Y into their respective slots.
REQ-018 COLLECT -> SEND on the cycle after loaded_mask becomes 5'b11111.
REQ-019 SEND: out_valid=1, out_idx starts at 0, out_data = slot[out_idx]; out_idx increments on each cycle with out_valid && out_ready.
REQ-020 out_data and out_idx shall remain stable while out_valid=1 and out_ready=0.
REQ-021 SEND -> FLUSH when slot 4 is accepted; FLUSH lasts one cycle, asserts done, clears loaded_mask, then -> COLLECT.
REQ-022 Accepted presses during SEND or FLUSH shall be ignored (slots and mask unchanged); debounce state still tracks the inputs.
REQ-023 Slot contents persist after FLUSH until overwritten; only the mask is cleared.
REQ-024 Latency: raw rising edge to mask-bit set = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; last capture to out_valid = 1 cycle.
REQ-025 busy = 1 exactly while in SEND; out_valid = 0 outside SEND.

Reset
REQ-026 rst shall force state COLLECT, out_valid=0, out_idx=0, out_data=0, loaded_mask=0, busy=0, done=0, all slots=0, synchronizers and debounced levels=0, counters=0.
REQ-027 rst asserted mid-SEND shall abort the stream on the same edge with no done pulse.
REQ-028 A button held through reset deassertion shall be accepted once after the debounce time.

Structure
REQ-029 Shared package pb_pkg holds the state enum (COLLECT, SEND, FLUSH), NUM_SLOTS=5, OPW=4, IDXW=3.
REQ-030 One sub-module, pb_debounce (synchronizer, counter, rising-edge pulse), instantiated five times; FSM and slot registers stay in the top.

Verification
REQ-031 DEBOUNCE_CYCLES=4, PB1 high for 3 cycles after sync, then low -> no capture, loaded_mask=0.
REQ-032 Press PB1..PB5 in turn with Y=1,2,3,4,8, out_ready=1 -> stream out_idx 0..4 with data 1,2,3,4,8 on consecutive cycles, then done pulse, mask=0.
REQ-033 PB3 pressed with Y=5 then again with Y=9 before completion -> slot 2 streams 9.
REQ-034 During SEND, out_ready low for 3 cycles at idx 2 -> out_idx=2 and out_data held; press of PB1 with Y=7 meanwhile -> ignored, slot 0 unchanged.
REQ-035 PB1..PB5 rise in the same cycle with Y=4'b1000 -> all slots 8, mask 11111, SEND entered one cycle later.
REQ-036 rst pulsed at out_idx=3 -> next cycle out_valid=0, mask=0, state COLLECT, no done pulse.
